riscv_timer: RTL

Memory-mapped machine timer that responds to the CPU data-memory port alongside the data memory. It holds a 64-bit free-running `mtime` counter advanced by a prescaler and a 64-bit `mtimecmp` compare register. It raises a level timer interrupt when `mtime >= mtimecmp`. Reads are combinational, matching the single-cycle data-memory read path; writes are byte-lane masked and take effect on the clock edge.

---
 rtl/riscv_timer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/riscv_timer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_timer
// Description : Memory-mapped machine timer on the CPU data-memory port.
//               64-bit free-running mtime advanced by a prescaler, 64-bit
//               mtimecmp, level interrupt when mtime >= mtimecmp.
//               Reads are combinational; writes are byte-lane masked and
//               take effect on the rising clock edge.
//
// Parameters  : PRESCALE  clock cycles per mtime increment (1..65536)
//               XLEN      data width (register map is 32-bit, keep at 32)
//
// Ports       : i_clk             system clock
//               i_rst             asynchronous active-high reset
//               i_timer_sel       access select from top-level decode
//               i_timer_addr      word offset (data address bits [4:2])
//               i_timer_wr_en     write strobe, qualified by i_timer_sel
//               i_timer_byte_sel  byte-lane enables
//               i_timer_wr_data   write data
//               o_timer_rd_data   read data (combinational)
//               o_timer_irq       registered timer interrupt level
//
// Register map: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//               4 CTRL (bit0 EN, bit1 IE), 5 STATUS (bit0 PEND, W1C),
//               6-7 unmapped.
//
// Option      : RISCV_TIMER_SNAPSHOT_EN - a read of MTIME_LO captures
//               mtime[63:32] into a shadow that MTIME_HI reads return,
//               giving a tear-free 64-bit read sequence.
//
// Revision    : 1.0  initial release
// ============================================================================
module riscv_timer #(
    parameter int PRESCALE = 1,
    parameter int XLEN     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_timer_sel,
    input  logic [2:0]      i_timer_addr,
    input  logic            i_timer_wr_en,
    input  logic [3:0]      i_timer_byte_sel,
    input  logic [XLEN-1:0] i_timer_wr_data,
    output logic [XLEN-1:0] o_timer_rd_data,
    output logic            o_timer_irq
);

    localparam logic [2:0]  C_MTIME_LO    = 3'd0;
    localparam logic [2:0]  C_MTIME_HI    = 3'd1;
    localparam logic [2:0]  C_MTIMECMP_LO = 3'd2;
    localparam logic [2:0]  C_MTIMECMP_HI = 3'd3;
    localparam logic [2:0]  C_CTRL        = 3'd4;
    localparam logic [2:0]  C_STATUS      = 3'd5;
    localparam logic [15:0] C_CNT_MAX     = 16'(PRESCALE - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [15:0] r_cnt;
    logic        r_en;
    logic        r_ie;
    logic        r_pend;
    logic        r_irq;

    logic        w_wr;
    logic        w_rd;
    logic        w_mtime_wr;
    logic        w_tick;
    logic        w_match;
    logic [31:0] w_mask;
    logic [31:0] w_mtime_hi_rd;

    // A write with no byte lanes enabled is treated as no access at all,
    // so it also leaves the prescaler alone.
    assign w_wr       = i_timer_sel & i_timer_wr_en & (|i_timer_byte_sel);
    assign w_rd       = i_timer_sel & ~i_timer_wr_en;
    assign w_mtime_wr = w_wr & ((i_timer_addr == C_MTIME_LO) |
                                (i_timer_addr == C_MTIME_HI));
    assign w_tick     = r_en & (r_cnt == C_CNT_MAX);
    assign w_match    = (r_mtime >= r_mtimecmp);
    assign w_mask     = {{8{i_timer_byte_sel[3]}}, {8{i_timer_byte_sel[2]}},
                         {8{i_timer_byte_sel[1]}}, {8{i_timer_byte_sel[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        merge = (old_val & ~mask) | (new_val & mask);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= {64{1'b1}};
            r_cnt      <= 16'd0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            // Prescaler restarts on any mtime write so the next tick is a
            // full period after software sets the time.
            if (w_mtime_wr) begin
                r_cnt <= 16'd0;
            end else if (r_en) begin
                r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
            end

            // CPU write beats a same-cycle tick: no increment at all.
            if (w_wr && i_timer_addr == C_MTIME_LO) begin
                r_mtime[31:0] <= merge(r_mtime[31:0], i_timer_wr_data, w_mask);
            end else if (w_wr && i_timer_addr == C_MTIME_HI) begin
                r_mtime[63:32] <= merge(r_mtime[63:32], i_timer_wr_data, w_mask);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && i_timer_addr == C_MTIMECMP_LO) begin
                r_mtimecmp[31:0] <= merge(r_mtimecmp[31:0], i_timer_wr_data, w_mask);
            end
            if (w_wr && i_timer_addr == C_MTIMECMP_HI) begin
                r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], i_timer_wr_data, w_mask);
            end

            if (w_wr && i_timer_addr == C_CTRL && i_timer_byte_sel[0]) begin
                r_en <= i_timer_wr_data[0];
                r_ie <= i_timer_wr_data[1];
            end

            // Set has priority over the W1C clear.
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_wr && i_timer_addr == C_STATUS &&
                         i_timer_byte_sel[0] && i_timer_wr_data[0]) begin
                r_pend <= 1'b0;
            end

            r_irq <= r_ie & w_match;
        end
    end

`ifdef RISCV_TIMER_SNAPSHOT_EN
    logic [31:0] r_shadow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow <= 32'd0;
        end else if (w_wr && i_timer_addr == C_MTIME_HI) begin
            r_shadow <= merge(r_mtime[63:32], i_timer_wr_data, w_mask);
        end else if (w_rd && i_timer_addr == C_MTIME_LO) begin
            r_shadow <= r_mtime[63:32];
        end
    end

    assign w_mtime_hi_rd = r_shadow;
`else
    assign w_mtime_hi_rd = r_mtime[63:32];
`endif

    always_comb begin
        o_timer_rd_data = '0;
        if (w_rd) begin
            case (i_timer_addr)
                C_MTIME_LO:    o_timer_rd_data = r_mtime[31:0];
                C_MTIME_HI:    o_timer_rd_data = w_mtime_hi_rd;
                C_MTIMECMP_LO: o_timer_rd_data = r_mtimecmp[31:0];
                C_MTIMECMP_HI: o_timer_rd_data = r_mtimecmp[63:32];
                C_CTRL:        o_timer_rd_data = {30'd0, r_ie, r_en};
                C_STATUS:      o_timer_rd_data = {31'd0, r_pend};
                default:       o_timer_rd_data = '0;
            endcase
        end
    end

    assign o_timer_irq = r_irq;

endmodule
`default_nettype wire
